lz77_decoder_param: RTL and testbench

LZ77_DECODER_PARAM -- requirements
Module: lz77_decoder_param

---
 rtl/lz77_decoder_param_pkg.sv | 15 +
 rtl/lz77_search_buf.sv | 34 +++
 rtl/lz77_decoder_param.sv | 125 ++++++++++++
 tb/tb_lz77_decoder_param.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lz77_decoder_param_pkg.sv
// Shared definitions for the LZ77 decoder: FSM state encoding and
// default parameter values used by the top and the search buffer.
package lz77_decoder_param_pkg;

  localparam int         DEF_DATA_W   = 8;
  localparam int         DEF_DEPTH    = 16;
  localparam logic [7:0] DEF_END_CHAR = 8'h24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lz77_search_buf.sv
// Search buffer: a DEPTH-entry shift register of decoded characters with a
// single indexed read port. Entry 0 always holds the most recent character.
module lz77_search_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int POS_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  input  logic [POS_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DEPTH-1:0][DATA_W-1:0] ent;

  // Shift in the newest character at entry 0; reset clears every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        ent <= '0;
    else if (shift_en) ent <= {ent[DEPTH-2:0], din};
  end

  // Out-of-range indices can only exist when DEPTH is not a power of two.
  generate
    if ((1 << POS_W) > DEPTH) begin : g_guard
      localparam logic [POS_W:0] DEPTH_C = (POS_W+1)'(DEPTH);
      assign rd_data = ({1'b0, rd_idx} < DEPTH_C) ? ent[rd_idx] : '0;
    end else begin : g_direct
      assign rd_data = ent[rd_idx];
    end
  endgenerate

endmodule

// File: rtl/lz77_decoder_param.sv
// LZ77 decoder: accepts (pos, len, char) triples, emits len characters copied
// from the search buffer followed by the literal char. A literal END_CHAR
// ends the stream and parks the FSM in DONE until reset.
module lz77_decoder_param
  import lz77_decoder_param_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter int                POS_W    = $clog2(DEPTH),
  parameter int                LEN_W    = 4,
  parameter logic [DATA_W-1:0] END_CHAR = DATA_W'(DEF_END_CHAR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [POS_W-1:0]  code_pos,
  input  logic [LEN_W-1:0]  code_len,
  input  logic [DATA_W-1:0] chardata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              finish,
  output logic              pos_err
);

  state_t              state_q, state_d;
  logic [POS_W-1:0]    pos_q;
  logic [LEN_W-1:0]    len_q, cnt_q;
  logic [DATA_W-1:0]   char_q;
  logic [DATA_W-1:0]   rd_data, ld_val;
  logic                out_end;
  logic                accept, load, is_last, pos_over;

  // Held low while reset is asserted, not just once the state resets.
  assign code_ready = reset && (state_q == IDLE);
  assign accept     = code_valid && code_ready;
  assign is_last    = (cnt_q == len_q);
  assign ld_val     = is_last ? char_q : rd_data;

  generate
    if ((1 << POS_W) > DEPTH) begin : g_pos_chk
      localparam logic [POS_W:0] DEPTH_C = (POS_W+1)'(DEPTH);
      assign pos_over = ({1'b0, code_pos} >= DEPTH_C);
    end else begin : g_pos_ok
      assign pos_over = 1'b0;
    end
  endgenerate

  lz77_search_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .POS_W  (POS_W)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .shift_en (load),
    .din      (ld_val),
    .rd_idx   (pos_q),
    .rd_data  (rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and load strobe; a load happens whenever the output slot is free.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = EMIT;
      EMIT: begin
        if (!out_valid || out_ready) begin
          load = 1'b1;
          if (is_last) state_d = (char_q == END_CHAR) ? DONE : IDLE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Triple capture, emit counter and sticky position error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q   <= '0;
      len_q   <= '0;
      char_q  <= '0;
      cnt_q   <= '0;
      pos_err <= 1'b0;
    end else if (accept) begin
      pos_q  <= pos_over ? '0 : code_pos;
      len_q  <= code_len;
      char_q <= chardata;
      cnt_q  <= '0;
      if (pos_over) pos_err <= 1'b1;
    end else if (load && !is_last) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Output register; out_end marks a literal END_CHAR so a copied one
  // never raises finish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_end   <= 1'b0;
      finish    <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= ld_val;
        out_end   <= is_last && (char_q == END_CHAR);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready && out_end) finish <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lz77_decoder_param.sv
// Directed bench for lz77_decoder_param: scoreboard queues filled from a
// reference LZ77 model at stimulus time and drained by output monitors.
module tb_lz77_decoder_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid, out_ready;
  logic [3:0] code_pos, code_len;
  logic [7:0] chardata;
  logic       code_ready, out_valid, finish, pos_err;
  logic [7:0] out_data;

  logic       code_valid12;
  logic [3:0] code_pos12, code_len12;
  logic [7:0] chardata12;
  logic       code_ready12, out_valid12, finish12, pos_err12;
  logic [7:0] out_data12;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp12_q[$];
  logic [7:0] mb[16];
  logic       hold_prev = 1'b0;
  logic [7:0] held      = '0;

  always #5 clk = ~clk;

  lz77_decoder_param dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code_ready(code_ready),
    .code_pos(code_pos), .code_len(code_len), .chardata(chardata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .finish(finish), .pos_err(pos_err)
  );

  lz77_decoder_param #(.DEPTH(12), .POS_W(4)) dut12 (
    .clk(clk), .reset(reset), .code_valid(code_valid12), .code_ready(code_ready12),
    .code_pos(code_pos12), .code_len(code_len12), .chardata(chardata12),
    .out_valid(out_valid12), .out_ready(1'b1), .out_data(out_data12),
    .finish(finish12), .pos_err(pos_err12)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    tests++;
    fails++;
    $error("FAIL %s: observed timeout/unexpected expected event", tag);
  endtask

  task automatic model_clear();
    for (int j = 0; j < 16; j++) mb[j] = '0;
  endtask

  // Reference decode of one triple into the scoreboard, then the handshake.
  task automatic send(input logic [3:0] p, input logic [3:0] l, input logic [7:0] c);
    logic [7:0] v;
    int n;
    for (int i = 0; i <= int'(l); i++) begin
      v = (i == int'(l)) ? c : mb[p];
      exp_q.push_back(v);
      for (int j = 15; j > 0; j--) mb[j] = mb[j-1];
      mb[0] = v;
    end
    code_pos = p; code_len = l; chardata = c; code_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!code_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("accept_timeout");
    @(posedge clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic send12(input logic [3:0] p, input logic [3:0] l, input logic [7:0] c);
    int n;
    code_pos12 = p; code_len12 = l; chardata12 = c; code_valid12 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!code_ready12 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("accept12_timeout");
    @(posedge clk); #1;
    code_valid12 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp12_q.size() != 0) && n < 300) begin
      @(posedge clk); n++;
    end
    if (n >= 300) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  // Output monitor: scoreboard compare and stall stability.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset && hold_prev) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(held));
    end
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) fail_now("extra_output");
      else begin
        e = exp_q.pop_front();
        check("out_seq", 32'(out_data), 32'(e));
      end
    end
    hold_prev = reset && out_valid && !out_ready;
    held      = out_data;
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (reset && out_valid12) begin
      if (exp12_q.size() == 0) fail_now("extra_output12");
      else begin
        e = exp12_q.pop_front();
        check("out_seq12", 32'(out_data12), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; out_ready = 1'b1;
    code_valid = 1'b0; code_pos = '0; code_len = '0; chardata = '0;
    code_valid12 = 1'b0; code_pos12 = '0; code_len12 = '0; chardata12 = '0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_code_ready", 32'(code_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_pos_err", 32'(pos_err), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(code_ready), 32'd1);

    // Literal-only triple with latency check
    send(4'd0, 4'd0, "a");
    check("lat_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lit_data", 32'(out_data), 32'(8'h61));
    drain();

    // Overlapping copy: a a a b
    send(4'd0, 4'd3, "b");
    drain();

    // Backpressure mid-copy
    send(4'd1, 4'd5, "c");
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-EMIT during a len=7 copy
    send(4'd0, 4'd7, "q");
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_ready", 32'(code_ready), 32'd0);
    check("mid_rst_finish", 32'(finish), 32'd0);
    exp_q.delete();
    model_clear();
    @(posedge clk); #1;
    check("mid_rst_hold", 32'(out_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(code_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    send(4'd5, 4'd2, "z");  // copies must read cleared entries
    drain();

    // Termination after "xy"
    send(4'd0, 4'd0, "x");
    send(4'd0, 4'd0, "y");
    send(4'd1, 4'd2, 8'h24);
    n = 0;
    @(negedge clk);
    while (!(out_valid && out_data == 8'h24) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("end_timeout");
    check("finish_before", 32'(finish), 32'd0);
    @(posedge clk); #1;
    check("finish_set", 32'(finish), 32'd1);
    code_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("done_ready", 32'(code_ready), 32'd0);
      check("done_valid", 32'(out_valid), 32'd0);
    end
    code_valid = 1'b0;
    check("finish_sticky", 32'(finish), 32'd1);
    check("term_drained", 32'(exp_q.size()), 32'd0);

    // DEPTH=12 with an out-of-range position
    exp12_q.push_back("k");
    send12(4'd0, 4'd0, "k");
    check("pos_err12_clear", 32'(pos_err12), 32'd0);
    exp12_q.push_back("k");
    exp12_q.push_back("m");
    send12(4'd13, 4'd1, "m");
    check("pos_err12_set", 32'(pos_err12), 32'd1);
    drain();
    check("pos_err_main", 32'(pos_err), 32'd0);
    check("d12_drained", 32'(exp12_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
